scc_serial_rx_endpoint: RTL and testbench
=========================================

SCC_SERIAL_RX_ENDPOINT -- requirements
Module: scc_serial_rx_endpoint

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, minimum 2.
REQ-002 Parameter OVERSAMPLE, default 16: sample ticks per bit.
REQ-003 Port clk_14m  input  1: 14.32 MHz IIgs master clock; all logic on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high.
REQ-005 Port baud_div  input  16: clk_14m cycles per sample tick; 0 treated as 1; 93 gives about 9600 baud.
REQ-006 Port rxd  input  1: serial line driven by the SCC port A txd; idle high; asynchronous to clk_14m.
REQ-007 Port cts  output  1: flow control into the SCC port A cts; high means room available.
REQ-008 Port rx_data  output  8: FIFO head byte.
REQ-009 Port rx_valid  output  1: FIFO non-empty.
REQ-010 Port rx_ready  input  1: host pop; a pop occurs on a cycle where rx_valid and rx_ready are both high.
REQ-011 Port frame_err  output  1: one-cycle pulse when the stop bit is sampled low.
REQ-012 Port overrun  output  1: one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-013 Port fifo_count  output  $clog2(FIFO_DEPTH)+1: current occupancy.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer, both flops resetting to 1; all decoding uses the synchronized value.
REQ-015 Tick generator: the 16-bit counter counts 0..max(baud_div,1)-1 and emits a one-cycle tick on wrap; it SHALL be held at 0 while in IDLE or WAIT_HIGH.
REQ-016 FSM states are IDLE, START, DATA, STOP and WAIT_HIGH; frame format is 8N1, LSB first.
REQ-017 IDLE: a synchronized rxd of 0 moves to START and clears the tick counter and tick index.
REQ-018 START: at tick index OVERSAMPLE/2-1 (mid-bit), sample rxd; if 1, treat as a glitch and return to IDLE; if 0, go to DATA with the index cleared.
REQ-019 DATA: sample every OVERSAMPLE ticks, shifting each bit into the MSB of the shift register; after the 8th bit go to STOP.
REQ-020 STOP: after OVERSAMPLE ticks, sample rxd. On 1, push the byte and return to IDLE. On 0, pulse frame_err, discard the byte and go to WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until synchronized rxd is 1, then go to IDLE; this handles break conditions.
REQ-022 Push latency: rx_valid and fifo_count update on the cycle after the stop-bit sample.
REQ-023 FIFO: rx_data is the head entry, combinational from storage; pointers wrap modulo FIFO_DEPTH.
REQ-024 Push while full without a simultaneous pop: drop the byte and pulse overrun; FIFO contents are unchanged.
REQ-025 Push while full with a simultaneous pop: both are accepted and the count stays at FIFO_DEPTH.
REQ-026 Push and pop on the same cycle when not full: both are accepted and the count is unchanged.
REQ-027 A pop while empty is ignored.
REQ-028 cts SHALL be registered, high when fifo_count < FIFO_DEPTH-1; this leaves one slot for an in-flight byte.

Reset
REQ-029 On reset, outputs are: cts=1, rx_valid=0, rx_data=0, frame_err=0, overrun=0, fifo_count=0.
REQ-030 On reset, the FSM is IDLE, the counters and pointers are 0 and the synchronizers are 1.
REQ-031 Reset mid-frame SHALL abandon the partial byte; no push and no pulse follow deassertion.

Structure
REQ-032 Package scc_iigs_pkg holds the FSM state enum, the OVERSAMPLE default, the FIFO_DEPTH default and the 9600-baud divisor constant (93).
REQ-033 Sub-module scc_rx_fifo holds the storage, pointers, count and push/pop arbitration; the top level holds the synchronizer, tick generator, FSM and cts register.

Verification
REQ-034 baud_div=93, send 8N1 byte 0x55 on rxd -> rx_valid rises about 9.5 bit times after the start edge, rx_data=0x55, fifo_count=1, no pulses.
REQ-035 rxd low for 4 ticks, then high -> FSM returns to IDLE, no push and no frame_err; a following byte 0xC3 is received correctly.
REQ-036 Byte 0xA3 sent with the stop bit low, line held low 3 bit times, then byte 0x12 -> exactly one frame_err pulse, 0xA3 is not stored, 0x12 is received.
REQ-037 rx_ready=0, send 0x01..0x05 -> cts falls after the 3rd byte; count=4 after the 4th; the 5th byte pulses overrun; pop order is 0x01..0x04.
REQ-038 FIFO full with rx_ready=1 held on the stop-sample cycle of byte 0x66 -> count stays 4 and 0x66 is last in pop order.
REQ-039 Assert reset during DATA bit 4 of byte 0x9C -> after release, all outputs are at reset values; a following byte 0x3A is received alone.

Source files
------------

// File: rtl/scc_iigs_pkg.sv
// Shared definitions for the IIgs SCC serial receive endpoint.
//   - rx_state_t        : receiver FSM states
//   - SCC_OVERSAMPLE_DEF: default sample ticks per bit
//   - SCC_FIFO_DEPTH_DEF: default receive FIFO depth
//   - SCC_BAUD_DIV_9600 : clk_14m cycles per sample tick for ~9600 baud
package scc_iigs_pkg;

  localparam int unsigned SCC_OVERSAMPLE_DEF = 16;
  localparam int unsigned SCC_FIFO_DEPTH_DEF = 4;
  localparam logic [15:0] SCC_BAUD_DIV_9600  = 16'd93;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/scc_rx_fifo.sv
// Receive byte FIFO for the SCC serial endpoint.
// Ports:
//   clk_14m, reset  : clock, asynchronous active-high reset
//   i_push/i_data   : byte to store (dropped with o_overrun if full and no pop)
//   i_pop           : pop request, ignored while empty
//   o_head/o_valid  : head entry (combinational from storage) / non-empty
//   o_count         : occupancy 0..DEPTH
//   o_overrun       : one-cycle pulse when a push is dropped
module scc_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_14m,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overrun
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;

  logic w_pop;
  logic w_full;
  logic w_wr;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_full = (r_count == CW'(DEPTH));
  // A pop on the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr   = i_push && (!w_full || w_pop);

  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      r_overrun <= i_push && w_full && !w_pop;
    end
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_valid   = (r_count != '0);
  assign o_count   = r_count;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/scc_serial_rx_endpoint.sv
// 8N1 serial receiver fed by the SCC port A txd, with receive FIFO and
// registered cts flow control.
// Ports:
//   clk_14m    : 14.32 MHz master clock
//   reset      : asynchronous, active-high
//   baud_div   : clk_14m cycles per sample tick (0 behaves as 1)
//   rxd        : asynchronous serial input, idle high
//   cts        : high while the FIFO has room beyond one in-flight byte
//   rx_data    : FIFO head byte; rx_valid: FIFO non-empty
//   rx_ready   : host pop when rx_valid is high
//   frame_err  : pulse when the stop bit is sampled low
//   overrun    : pulse when a good byte is dropped on a full FIFO
//   fifo_count : FIFO occupancy
module scc_serial_rx_endpoint
  import scc_iigs_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = SCC_FIFO_DEPTH_DEF,
  parameter int unsigned OVERSAMPLE = SCC_OVERSAMPLE_DEF
) (
  input  logic                          clk_14m,
  input  logic                          reset,
  input  logic [15:0]                   baud_div,
  input  logic                          rxd,
  output logic                          cts,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);

  logic             r_rxd_meta;
  logic             r_rxd_sync;
  rx_state_t        r_state;
  logic [15:0]      r_tick_cnt;
  logic [IDX_W-1:0] r_tick_idx;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_frame_err;
  logic             r_cts;

  rx_state_t        w_state_nxt;
  logic [15:0]      w_tick_cnt_nxt;
  logic [IDX_W-1:0] w_tick_idx_nxt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_push;
  logic             w_frame_err_nxt;
  logic [15:0]      w_div_last;
  logic             w_tick;
  logic [CW-1:0]    w_fifo_count;

  assign w_div_last = (baud_div == '0) ? '0 : baud_div - 16'd1;
  assign w_tick     = (r_tick_cnt == w_div_last);

  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) begin
      r_rxd_meta  <= 1'b1;
      r_rxd_sync  <= 1'b1;
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_tick_idx  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_cts       <= 1'b1;
    end else begin
      r_rxd_meta  <= rxd;
      r_rxd_sync  <= r_rxd_meta;
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_tick_idx  <= w_tick_idx_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_cts       <= (w_fifo_count < CW'(FIFO_DEPTH - 1));
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_tick_idx_nxt  = r_tick_idx;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_push          = 1'b0;
    w_frame_err_nxt = 1'b0;

    if (r_state == ST_IDLE || r_state == ST_WAIT_HIGH) w_tick_cnt_nxt = '0;
    else w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + 16'd1;

    case (r_state)
      ST_IDLE: begin
        w_tick_idx_nxt = '0;
        w_bit_cnt_nxt  = '0;
        if (!r_rxd_sync) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_tick) begin
          if (r_tick_idx == IDX_MID) begin
            w_tick_idx_nxt = '0;
            w_state_nxt    = r_rxd_sync ? ST_IDLE : ST_DATA;
          end else begin
            w_tick_idx_nxt = r_tick_idx + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_tick_idx == IDX_LAST) begin
            w_tick_idx_nxt = '0;
            w_shift_nxt    = {r_rxd_sync, r_shift[7:1]};
            w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_state_nxt = ST_STOP;
          end else begin
            w_tick_idx_nxt = r_tick_idx + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_tick_idx == IDX_LAST) begin
            w_tick_idx_nxt = '0;
            if (r_rxd_sync) begin
              w_push      = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_frame_err_nxt = 1'b1;
              w_state_nxt     = ST_WAIT_HIGH;
            end
          end else begin
            w_tick_idx_nxt = r_tick_idx + 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (r_rxd_sync) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  scc_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_14m  (clk_14m),
    .reset    (reset),
    .i_push   (w_push),
    .i_data   (r_shift),
    .i_pop    (rx_ready),
    .o_head   (rx_data),
    .o_valid  (rx_valid),
    .o_count  (w_fifo_count),
    .o_overrun(overrun)
  );

  assign fifo_count = w_fifo_count;
  assign frame_err  = r_frame_err;
  assign cts        = r_cts;

endmodule

// File: tb/tb_scc_serial_rx_endpoint.sv
module tb_scc_serial_rx_endpoint;
  import scc_iigs_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OS    = 16;

  localparam int K_GOOD   = 0;
  localparam int K_BAD    = 1;
  localparam int K_GLITCH = 2;

  logic        clk_14m  = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] baud_div = SCC_BAUD_DIV_9600;
  logic        rxd      = 1'b1;
  logic        rx_ready = 1'b0;
  logic        cts;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic [2:0]  fifo_count;

  scc_serial_rx_endpoint #(
    .FIFO_DEPTH(DEPTH),
    .OVERSAMPLE(OS)
  ) dut (
    .clk_14m   (clk_14m),
    .reset     (reset),
    .baud_div  (baud_div),
    .rxd       (rxd),
    .cts       (cts),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .fifo_count(fifo_count)
  );

  always #5 clk_14m = ~clk_14m;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  logic prev_valid = 1'b0;
  int unsigned valid_rise_cyc = 0;

  always @(posedge clk_14m) cyc <= cyc + 1;

  always @(negedge clk_14m) begin
    if (!reset) begin
      if (frame_err) fe_seen++;
      if (overrun)   ov_seen++;
      if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned ticklen(input logic [15:0] d);
    return (d == 16'd0) ? 1 : int'(d);
  endfunction

  function automatic int unsigned bitlen(input logic [15:0] d);
    return OS * ticklen(d);
  endfunction

  // Start bit, 8 data bits LSB first, stop bit at stop_lvl; a low stop is
  // extended by low_after extra bit times, then two idle bit times.
  task automatic send_frame(input logic [7:0] data, input logic stop_lvl,
                            input int unsigned low_after);
    int unsigned b;
    b = bitlen(baud_div);
    @(posedge clk_14m); #1 rxd = 1'b0;
    repeat (b) @(posedge clk_14m);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = data[i];
      repeat (b) @(posedge clk_14m);
    end
    #1 rxd = stop_lvl;
    repeat (b * (1 + (stop_lvl ? 0 : low_after))) @(posedge clk_14m);
    #1 rxd = 1'b1;
    repeat (2 * b) @(posedge clk_14m);
    #1;
  endtask

  task automatic send_glitch(input int unsigned ticks);
    @(posedge clk_14m); #1 rxd = 1'b0;
    repeat (ticks * ticklen(baud_div)) @(posedge clk_14m);
    #1 rxd = 1'b1;
    repeat (2 * bitlen(baud_div)) @(posedge clk_14m);
    #1;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check({name, " valid"}, int'(rx_valid), 1);
    check({name, " data"}, int'(rx_data), int'(exp));
    rx_ready = 1'b1;
    @(posedge clk_14m); #1 rx_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " cts"},       int'(cts), 1);
    check({name, " rx_valid"},  int'(rx_valid), 0);
    check({name, " rx_data"},   int'(rx_data), 0);
    check({name, " frame_err"}, int'(frame_err), 0);
    check({name, " overrun"},   int'(overrun), 0);
    check({name, " count"},     int'(fifo_count), 0);
  endtask

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         exp_count;
    logic       exp_cts;
    int         exp_fe;
    int         exp_ov;
    logic [7:0] exp_head;
  } vec_t;

  vec_t tbl [9];
  logic [7:0] q [$];

  initial begin
    int unsigned d_rise;
    int unsigned b;
    int fe0, ov0, exp_fe, exp_ov, kind, npop;
    logic [7:0] data;
    logic [7:0] b9c;

    tbl[0] = '{K_GLITCH, 8'h00, 0, 1'b1, 0, 0, 8'h00};
    tbl[1] = '{K_GOOD,   8'hC3, 1, 1'b1, 0, 0, 8'hC3};
    tbl[2] = '{K_BAD,    8'hA3, 1, 1'b1, 1, 0, 8'hC3};
    tbl[3] = '{K_GOOD,   8'h12, 2, 1'b1, 1, 0, 8'hC3};
    tbl[4] = '{K_GOOD,   8'h01, 1, 1'b1, 1, 0, 8'h01};
    tbl[5] = '{K_GOOD,   8'h02, 2, 1'b1, 1, 0, 8'h01};
    tbl[6] = '{K_GOOD,   8'h03, 3, 1'b0, 1, 0, 8'h01};
    tbl[7] = '{K_GOOD,   8'h04, 4, 1'b0, 1, 0, 8'h01};
    tbl[8] = '{K_GOOD,   8'h05, 4, 1'b0, 1, 1, 8'h01};

    // Reset values, during and after reset
    repeat (3) @(posedge clk_14m);
    #1 check_reset_outputs("in_reset");
    reset = 1'b0;
    repeat (4) @(posedge clk_14m);
    #1 check_reset_outputs("post_reset");

    // 0x55 at ~9600 baud: rx_valid about 9.5 bit times after the start edge
    baud_div = SCC_BAUD_DIV_9600;
    b = bitlen(baud_div);
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        @(posedge clk_14m); #1 d_rise = cyc;
      end
    join
    check("9600 rise window", int'((valid_rise_cyc - d_rise) >= 9 * b &&
                                   (valid_rise_cyc - d_rise) <= 10 * b), 1);
    check("9600 count", int'(fifo_count), 1);
    check("9600 frame_err", fe_seen, 0);
    check("9600 overrun", ov_seen, 0);
    pop_expect("9600 pop", 8'h55);
    check("9600 drained", int'(fifo_count), 0);
    rx_ready = 1'b1;
    @(posedge clk_14m); #1 rx_ready = 1'b0;
    check("pop empty count", int'(fifo_count), 0);
    check("pop empty valid", int'(rx_valid), 0);

    // Directed table at a fast divisor
    baud_div = 16'd3;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        pop_expect("drainA 0", 8'hC3);
        pop_expect("drainA 1", 8'h12);
        check("drainA count", int'(fifo_count), 0);
      end
      case (tbl[i].kind)
        K_GOOD:  send_frame(tbl[i].data, 1'b1, 0);
        K_BAD:   send_frame(tbl[i].data, 1'b0, 3);
        default: send_glitch(4);
      endcase
      check($sformatf("tbl%0d count", i), int'(fifo_count), tbl[i].exp_count);
      check($sformatf("tbl%0d cts", i), int'(cts), int'(tbl[i].exp_cts));
      check($sformatf("tbl%0d frame_err", i), fe_seen, tbl[i].exp_fe);
      check($sformatf("tbl%0d overrun", i), ov_seen, tbl[i].exp_ov);
      if (tbl[i].exp_count != 0)
        check($sformatf("tbl%0d head", i), int'(rx_data), int'(tbl[i].exp_head));
    end

    // Full FIFO, pop held on the stop-sample cycle of 0x66. The stop sample
    // lands 2 sync cycles + 1 idle-detect cycle + (OS/2 + 9*OS) ticks after
    // the start edge; rx_ready is high during the cycle before that edge.
    fork
      send_frame(8'h66, 1'b1, 0);
      begin
        @(posedge clk_14m);
        repeat (2 + (OS / 2 + 9 * OS) * ticklen(baud_div)) @(posedge clk_14m);
        #1;
        check("full pop count", int'(fifo_count), 4);
        check("full pop head", int'(rx_data), 8'h01);
        rx_ready = 1'b1;
        @(posedge clk_14m); #1 rx_ready = 1'b0;
      end
    join
    check("full push+pop count", int'(fifo_count), 4);
    check("full push+pop overrun", ov_seen, 1);
    pop_expect("drainB 0", 8'h02);
    pop_expect("drainB 1", 8'h03);
    pop_expect("drainB 2", 8'h04);
    check("drainB head", int'(rx_data), 8'h66);
    check("drainB count", int'(fifo_count), 1);

    // Reset in the middle of data bit 4 of 0x9C
    fe0 = fe_seen;
    ov0 = ov_seen;
    b9c = 8'h9C;
    b = bitlen(baud_div);
    @(posedge clk_14m); #1 rxd = 1'b0;
    repeat (b) @(posedge clk_14m);
    for (int i = 0; i < 5; i++) begin
      #1 rxd = b9c[i];
      repeat ((i == 4) ? b / 2 : b) @(posedge clk_14m);
    end
    #1 reset = 1'b1;
    rxd = 1'b1;
    repeat (5) @(posedge clk_14m);
    #1 reset = 1'b0;
    repeat (3 * b) @(posedge clk_14m);
    #1 check_reset_outputs("mid_frame_reset");
    check("mid_frame_reset fe", fe_seen, fe0);
    check("mid_frame_reset ov", ov_seen, ov0);
    send_frame(8'h3A, 1'b1, 0);
    check("after reset count", int'(fifo_count), 1);
    check("after reset fe", fe_seen, fe0);
    pop_expect("after reset pop", 8'h3A);
    check("after reset drained", int'(fifo_count), 0);

    // Randomized frames against a queue model of the FIFO
    q.delete();
    exp_fe = fe_seen;
    exp_ov = ov_seen;
    for (int n = 0; n < 30; n++) begin
      baud_div = 16'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 9));
      data = 8'($urandom);
      if (kind < 6) begin
        send_frame(data, 1'b1, 0);
        if (q.size() < DEPTH) q.push_back(data);
        else exp_ov++;
      end else if (kind < 8) begin
        send_frame(data, 1'b0, $urandom_range(0, 2));
        exp_fe++;
      end else begin
        send_glitch($urandom_range(1, OS / 2 - 2));
      end
      check($sformatf("rnd%0d count", n), int'(fifo_count), q.size());
      check($sformatf("rnd%0d cts", n), int'(cts), int'(q.size() < DEPTH - 1));
      check($sformatf("rnd%0d frame_err", n), fe_seen, exp_fe);
      check($sformatf("rnd%0d overrun", n), ov_seen, exp_ov);
      npop = int'($urandom_range(0, 2));
      for (int p = 0; p < npop; p++) begin
        if (q.size() > 0) begin
          pop_expect($sformatf("rnd%0d pop%0d", n, p), q.pop_front());
        end else begin
          rx_ready = 1'b1;
          @(posedge clk_14m); #1 rx_ready = 1'b0;
        end
      end
      check($sformatf("rnd%0d count after pop", n), int'(fifo_count), q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
